// File: rtl/display_pkg.sv
// Shared constants, state encoding and counter sizing for the display scheduler.
package display_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;

    localparam logic [DIGIT_W-1:0]            BLANK_DIGIT = 4'hF;
    localparam logic [NUM_DIGITS*DIGIT_W-1:0] ALL_BLANK   = {NUM_DIGITS{BLANK_DIGIT}};

    typedef enum logic [1:0] {
        IDLE,
        MSG,
        ALERT
    } state_t;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_sched_tick_timer.sv
// Counts tick pulses up to a runtime-selected terminal value; done pulses on the
// tick that reaches it and the counter restarts from zero on its own.
module tick_timer
    import display_pkg::*;
#(
    parameter int N = 2,
    localparam int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          tick,
    input  logic [CW-1:0] last,
    output logic          done
);

    logic [CW-1:0] cnt;

    assign done = tick && (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || done) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_sched.sv
// Arbitrates the 8-digit display between the background score, a timed message
// and a blinking alert (alert > message > score), with registered outputs.
module display_sched
    import display_pkg::*;
#(
    parameter int HOLD_TICKS  = 2000,
    parameter int BLINK_TICKS = 250,
    parameter int BLINK_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [31:0] score_digits,
    input  logic        msg_req,
    input  logic [31:0] msg_digits,
    output logic        msg_ack,
    input  logic        alert_req,
    input  logic [31:0] alert_digits,
    output logic        alert_ack,
    output logic [31:0] disp_digits,
    output logic        busy
);

    localparam int TMAX = (HOLD_TICKS > BLINK_TICKS) ? HOLD_TICKS : BLINK_TICKS;
    localparam int TW   = cnt_width(TMAX);
    localparam int BW   = cnt_width(BLINK_COUNT);

    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0] BLINK_LAST  = TW'(BLINK_TICKS - 1);
    localparam logic [BW-1:0] BLINKS_LAST = BW'(BLINK_COUNT - 1);

    state_t        state, next_state;
    logic          phase_on, next_phase_on;
    logic [BW-1:0] blinks, next_blinks;
    logic [31:0]   msg_latch, alert_latch, next_disp;
    logic          take_alert, take_msg;
    logic          timer_clear, timer_done;
    logic [TW-1:0] timer_last;

    // The timer restarts on every acceptance, so a tick in the accepting cycle is not counted.
    assign take_alert  = alert_req && (state != ALERT);
    assign take_msg    = msg_req && !alert_req && (state == IDLE);
    assign timer_clear = take_alert || take_msg;
    assign timer_last  = (state == ALERT) ? BLINK_LAST : HOLD_LAST;
    assign busy        = (state != IDLE);

    tick_timer #(.N(TMAX)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .tick  (tick),
        .last  (timer_last),
        .done  (timer_done)
    );

    always_comb begin
        next_state    = state;
        next_phase_on = phase_on;
        next_blinks   = blinks;
        next_disp     = score_digits;
        case (state)
            IDLE: begin
                next_disp = score_digits;
                if (take_msg) begin
                    next_state = MSG;
                end
            end
            MSG: begin
                next_disp = msg_latch;
                if (timer_done) begin
                    next_state = IDLE;
                end
            end
            ALERT: begin
                next_disp = phase_on ? alert_latch : ALL_BLANK;
                if (timer_done) begin
                    if (phase_on) begin
                        next_phase_on = 1'b0;
                    end else if (blinks == BLINKS_LAST) begin
                        next_state = IDLE;
                    end else begin
                        next_blinks   = blinks + 1'b1;
                        next_phase_on = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        // An accepted alert overrides whatever IDLE or MSG decided above.
        if (take_alert) begin
            next_state    = ALERT;
            next_phase_on = 1'b1;
            next_blinks   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase_on    <= 1'b0;
            blinks      <= '0;
            msg_latch   <= '0;
            alert_latch <= '0;
            disp_digits <= ALL_BLANK;
            msg_ack     <= 1'b0;
            alert_ack   <= 1'b0;
        end else begin
            state       <= next_state;
            phase_on    <= next_phase_on;
            blinks      <= next_blinks;
            disp_digits <= next_disp;
            msg_ack     <= take_msg;
            alert_ack   <= take_alert;
            if (take_msg) begin
                msg_latch <= msg_digits;
            end
            if (take_alert) begin
                alert_latch <= alert_digits;
            end
        end
    end

endmodule

// File: tb/tb_display_sched.sv
// Scoreboard bench for display_sched: a tick-level behavioural model predicts each
// cycle's outputs, and a negedge monitor compares them against the design.
module tb_display_sched;

    localparam int HOLD_TICKS  = 3;
    localparam int BLINK_TICKS = 2;
    localparam int BLINK_COUNT = 2;
    localparam logic [31:0] BLANK = 32'hFFFF_FFFF;
    localparam int M_IDLE  = 0;
    localparam int M_MSG   = 1;
    localparam int M_ALERT = 2;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic [31:0] score_digits;
    logic        msg_req;
    logic [31:0] msg_digits;
    logic        msg_ack;
    logic        alert_req;
    logic [31:0] alert_digits;
    logic        alert_ack;
    logic [31:0] disp_digits;
    logic        busy;

    typedef struct packed {
        logic [31:0] disp;
        logic        mack;
        logic        aack;
        logic        busy;
    } want_t;

    want_t want_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          m_mode;
    logic [31:0] m_msg, m_alert;
    int          m_ticks_left, m_pairs_left;
    bit          m_on, m_last_mack, m_last_aack;

    display_sched #(
        .HOLD_TICKS  (HOLD_TICKS),
        .BLINK_TICKS (BLINK_TICKS),
        .BLINK_COUNT (BLINK_COUNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .score_digits (score_digits),
        .msg_req      (msg_req),
        .msg_digits   (msg_digits),
        .msg_ack      (msg_ack),
        .alert_req    (alert_req),
        .alert_digits (alert_digits),
        .alert_ack    (alert_ack),
        .disp_digits  (disp_digits),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode       = M_IDLE;
        m_msg        = '0;
        m_alert      = '0;
        m_ticks_left = 0;
        m_pairs_left = 0;
        m_on         = 1'b0;
        m_last_mack  = 1'b0;
        m_last_aack  = 1'b0;
    endfunction

    // Outputs after this edge: display reflects the mode held before the edge, acks/busy the new mode.
    function automatic void model_step();
        want_t w;
        if (m_mode == M_IDLE)     w.disp = score_digits;
        else if (m_mode == M_MSG) w.disp = m_msg;
        else                      w.disp = m_on ? m_alert : BLANK;
        w.mack = 1'b0;
        w.aack = 1'b0;
        if (m_mode != M_ALERT && alert_req) begin
            w.aack       = 1'b1;
            m_alert      = alert_digits;
            m_mode       = M_ALERT;
            m_on         = 1'b1;
            m_ticks_left = BLINK_TICKS;
            m_pairs_left = BLINK_COUNT;
        end else if (m_mode == M_IDLE && msg_req) begin
            w.mack       = 1'b1;
            m_msg        = msg_digits;
            m_mode       = M_MSG;
            m_ticks_left = HOLD_TICKS;
        end else if (m_mode != M_IDLE && tick) begin
            m_ticks_left--;
            if (m_ticks_left == 0) begin
                if (m_mode == M_MSG) begin
                    m_mode = M_IDLE;
                end else if (m_on) begin
                    m_on         = 1'b0;
                    m_ticks_left = BLINK_TICKS;
                end else begin
                    m_pairs_left--;
                    if (m_pairs_left == 0) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_on         = 1'b1;
                        m_ticks_left = BLINK_TICKS;
                    end
                end
            end
        end
        w.busy = (m_mode != M_IDLE);
        m_last_mack = w.mack;
        m_last_aack = w.aack;
        want_q.push_back(w);
    endfunction

    task automatic apply_stimulus();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        if (m_last_mack) msg_req = 1'b0;
        if (m_last_aack) alert_req = 1'b0;
        m_last_mack = 1'b0;
        m_last_aack = 1'b0;
        cyc++;
        tick = (cyc % 4 == 3);
    endtask

    task automatic run_until_quiet(input int limit);
        for (int i = 0; i < limit; i++) begin
            apply_stimulus();
            if (!msg_req && !alert_req && m_mode == M_IDLE) break;
        end
        repeat (2) apply_stimulus();
    endtask

    initial begin
        want_t w;
        forever begin
            @(negedge clk);
            if (want_q.size() > 0) begin
                w = want_q.pop_front();
                check_output("disp_digits", disp_digits, w.disp);
                check_output("msg_ack", {31'b0, msg_ack}, {31'b0, w.mack});
                check_output("alert_ack", {31'b0, alert_ack}, {31'b0, w.aack});
                check_output("busy", {31'b0, busy}, {31'b0, w.busy});
            end
        end
    end

    initial begin
        rst_n        = 1'b1;
        tick         = 1'b0;
        msg_req      = 1'b0;
        alert_req    = 1'b0;
        score_digits = 32'h0000_1234;
        msg_digits   = '0;
        alert_digits = '0;
        model_reset();

        #2 rst_n = 1'b0;
        #1;
        check_output("reset_disp", disp_digits, BLANK);
        check_output("reset_busy", {31'b0, busy}, 32'h0);
        repeat (2) apply_stimulus();
        check_output("reset_hold_disp", disp_digits, BLANK);
        check_output("reset_hold_acks", {30'b0, msg_ack, alert_ack}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) apply_stimulus();

        msg_digits = 32'hFFFF_0042;
        msg_req    = 1'b1;
        run_until_quiet(100);

        alert_digits = 32'h8888_8888;
        msg_digits   = 32'h1234_5678;
        alert_req    = 1'b1;
        msg_req      = 1'b1;
        run_until_quiet(200);

        msg_digits = 32'h0000_0777;
        msg_req    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            apply_stimulus();
            if (m_mode == M_MSG && m_ticks_left == HOLD_TICKS - 1) break;
        end
        alert_digits = 32'h0000_0003;
        alert_req    = 1'b1;
        run_until_quiet(200);

        msg_digits = 32'hAAAA_0001;
        msg_req    = 1'b1;
        for (int i = 0; i < 20 && m_mode != M_MSG; i++) apply_stimulus();
        repeat (2) apply_stimulus();
        msg_digits = 32'hBBBB_0002;
        msg_req    = 1'b1;
        run_until_quiet(200);

        for (int i = 0; i < 400; i++) begin
            if (!msg_req && $urandom_range(0, 7) == 0) begin
                msg_digits = $urandom;
                msg_req    = 1'b1;
            end
            if (!alert_req && $urandom_range(0, 15) == 0) begin
                alert_digits = $urandom;
                alert_req    = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) score_digits = $urandom;
            apply_stimulus();
        end
        run_until_quiet(200);

        score_digits = 32'h0000_9876;
        alert_digits = 32'h5555_5555;
        alert_req    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            apply_stimulus();
            if (m_mode == M_ALERT && !m_on) break;
        end
        repeat (2) apply_stimulus();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("async_disp", disp_digits, BLANK);
        check_output("async_busy", {31'b0, busy}, 32'h0);
        check_output("async_acks", {30'b0, msg_ack, alert_ack}, 32'h0);
        model_reset();
        repeat (2) apply_stimulus();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) apply_stimulus();

        @(negedge clk);
        #1;
        check_output("queue_drained", want_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
